ay_bus_ctrl: RTL and testbench

Bus-side controller and register file for the AY-3-8913 core. Decodes the BDIR/BC2/BC1 bus protocol and latches the register address. Holds the 14 sound registers (R0–R13) and drives the configuration ports of the tone, noise, mixer, amplitude and envelope blocks. Generates the one-cycle envelope restart pulse whenever R13 is written.

---
 rtl/ay_bus_ctrl.sv | 132 +++++++++++++
 tb/tb_ay_bus_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ay_bus_ctrl.sv
// Bus-side controller for the AY-3-8913 core: decodes BDIR/BC2/BC1, latches the register address
// and holds R0-R13, driving the tone/noise/mixer/amplitude/envelope configuration ports.
module ay_bus_ctrl #(
    parameter logic [3:0] ADDR_HI = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bdir,
    input  logic        bc2,
    input  logic        bc1,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [11:0] tone_a_period,
    output logic [11:0] tone_b_period,
    output logic [11:0] tone_c_period,
    output logic [4:0]  noise_period,
    output logic [7:0]  mixer,
    output logic [4:0]  amp_a,
    output logic [4:0]  amp_b,
    output logic [4:0]  amp_c,
    output logic [15:0] env_period,
    output logic        continue_,
    output logic        attack,
    output logic        alternate,
    output logic        hold,
    output logic        env_restart
);

    typedef enum logic [1:0] {IDLE, LATCH, READ, WRITE} state_e;

    state_e     state_q, state_d;
    logic [7:0] latch_q, latch_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [3:0] addr_q, addr_d;
    logic       sel_q, sel_d;
    logic [7:0] regs_q [14];
    logic [7:0] regs_d [14];
    logic       commit;
    logic [7:0] rd_data;
    logic       data_oe_q, data_oe_d;
    logic [7:0] data_out_q, data_out_d;
    logic       env_restart_q, env_restart_d;

    // Bits a register does not implement are dropped on write and read back as zero.
    function automatic logic [7:0] regMask(input logic [3:0] a);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13: regMask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: regMask = 8'h1F;
            4'd14, 4'd15:            regMask = 8'h00;
            default:                 regMask = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        case ({bdir, bc2, bc1})
            3'b001, 3'b100, 3'b111: state_d = LATCH;
            3'b011:                 state_d = READ;
            3'b110:                 state_d = WRITE;
            default:                state_d = IDLE;
        endcase
    end

    // Address and write commits act on the edge that leaves LATCH/WRITE; reads see those same-edge results.
    always_comb begin
        latch_d   = (state_d == LATCH) ? data_in : latch_q;
        wr_data_d = (state_d == WRITE) ? data_in : wr_data_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        if (state_q == LATCH && state_d != LATCH) begin
            addr_d = latch_q[3:0];
            sel_d  = (latch_q[7:4] == ADDR_HI);
        end
        commit = (state_q == WRITE) && (state_d != WRITE) && sel_q;
        regs_d = regs_q;
        for (int i = 0; i < 14; i++) begin
            if (commit && addr_q == 4'(i)) regs_d[i] = wr_data_q & regMask(4'(i));
        end
        env_restart_d = commit && (addr_q == 4'd13);
        rd_data = 8'h00;
        for (int i = 0; i < 14; i++) begin
            if (addr_d == 4'(i)) rd_data = regs_d[i] & regMask(4'(i));
        end
        data_oe_d  = (state_d == READ) && sel_d;
        data_out_d = data_oe_d ? rd_data : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q       <= 8'h00;
            wr_data_q     <= 8'h00;
            addr_q        <= 4'h0;
            sel_q         <= 1'b0;
            data_oe_q     <= 1'b0;
            data_out_q    <= 8'h00;
            env_restart_q <= 1'b0;
            for (int i = 0; i < 14; i++) regs_q[i] <= 8'h00;
        end else begin
            latch_q       <= latch_d;
            wr_data_q     <= wr_data_d;
            addr_q        <= addr_d;
            sel_q         <= sel_d;
            data_oe_q     <= data_oe_d;
            data_out_q    <= data_out_d;
            env_restart_q <= env_restart_d;
            regs_q        <= regs_d;
        end
    end

    assign data_out      = data_out_q;
    assign data_oe       = data_oe_q;
    assign tone_a_period = {regs_q[1][3:0], regs_q[0]};
    assign tone_b_period = {regs_q[3][3:0], regs_q[2]};
    assign tone_c_period = {regs_q[5][3:0], regs_q[4]};
    assign noise_period  = regs_q[6][4:0];
    assign mixer         = regs_q[7];
    assign amp_a         = regs_q[8][4:0];
    assign amp_b         = regs_q[9][4:0];
    assign amp_c         = regs_q[10][4:0];
    assign env_period    = {regs_q[12], regs_q[11]};
    assign continue_     = regs_q[13][3];
    assign attack        = regs_q[13][2];
    assign alternate     = regs_q[13][1];
    assign hold          = regs_q[13][0];
    assign env_restart   = env_restart_q;

endmodule

// File: tb/tb_ay_bus_ctrl.sv
// Directed testbench for ay_bus_ctrl: one chip at ADDR_HI=0 and one at ADDR_HI=1 share the bus.
module tb_ay_bus_ctrl;

    localparam logic [2:0] C_INACT = 3'b000;
    localparam logic [2:0] C_IDLE2 = 3'b101;
    localparam logic [2:0] C_LATCH = 3'b001;
    localparam logic [2:0] C_LAT2  = 3'b100;
    localparam logic [2:0] C_LAT3  = 3'b111;
    localparam logic [2:0] C_READ  = 3'b011;
    localparam logic [2:0] C_WRITE = 3'b110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       bdir, bc2, bc1;
    logic [7:0] data_in;

    logic [7:0]  d0_data_out, d1_data_out;
    logic        d0_data_oe, d1_data_oe;
    logic [11:0] d0_tone_a, d0_tone_b, d0_tone_c, d1_tone_a, d1_tone_b, d1_tone_c;
    logic [4:0]  d0_noise, d1_noise;
    logic [7:0]  d0_mixer, d1_mixer;
    logic [4:0]  d0_amp_a, d0_amp_b, d0_amp_c, d1_amp_a, d1_amp_b, d1_amp_c;
    logic [15:0] d0_env_period, d1_env_period;
    logic        d0_cont, d0_att, d0_alt, d0_hold, d1_cont, d1_att, d1_alt, d1_hold;
    logic        d0_env_restart, d1_env_restart;

    int checks = 0;
    int fails  = 0;

    ay_bus_ctrl #(.ADDR_HI(4'h0)) dut0 (
        .clk(clk), .reset(reset), .bdir(bdir), .bc2(bc2), .bc1(bc1), .data_in(data_in),
        .data_out(d0_data_out), .data_oe(d0_data_oe),
        .tone_a_period(d0_tone_a), .tone_b_period(d0_tone_b), .tone_c_period(d0_tone_c),
        .noise_period(d0_noise), .mixer(d0_mixer),
        .amp_a(d0_amp_a), .amp_b(d0_amp_b), .amp_c(d0_amp_c), .env_period(d0_env_period),
        .continue_(d0_cont), .attack(d0_att), .alternate(d0_alt), .hold(d0_hold),
        .env_restart(d0_env_restart)
    );

    ay_bus_ctrl #(.ADDR_HI(4'h1)) dut1 (
        .clk(clk), .reset(reset), .bdir(bdir), .bc2(bc2), .bc1(bc1), .data_in(data_in),
        .data_out(d1_data_out), .data_oe(d1_data_oe),
        .tone_a_period(d1_tone_a), .tone_b_period(d1_tone_b), .tone_c_period(d1_tone_c),
        .noise_period(d1_noise), .mixer(d1_mixer),
        .amp_a(d1_amp_a), .amp_b(d1_amp_b), .amp_c(d1_amp_c), .env_period(d1_env_period),
        .continue_(d1_cont), .attack(d1_att), .alternate(d1_alt), .hold(d1_hold),
        .env_restart(d1_env_restart)
    );

    // Drive one bus cycle; on return the outputs reflect the edge that sampled it.
    task automatic step(input logic [2:0] code, input logic [7:0] d);
        {bdir, bc2, bc1} = code;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(C_INACT, 8'h00);
        step(C_INACT, 8'h00);
        checks++; if (d0_data_oe !== 1'b0) begin fails++; $display("[TB] FAIL reset_oe got %0h want 0", d0_data_oe); end
        checks++; if (d0_data_out !== 8'h00) begin fails++; $display("[TB] FAIL reset_dout got %0h want 0", d0_data_out); end
        checks++; if (d0_env_restart !== 1'b0) begin fails++; $display("[TB] FAIL reset_restart got %0h want 0", d0_env_restart); end
        checks++; if ({d0_tone_a, d0_env_period, d0_mixer} !== 36'h0) begin fails++; $display("[TB] FAIL reset_cfg got %0h want 0", {d0_tone_a, d0_env_period, d0_mixer}); end
        reset = 1'b0;
        step(C_READ, 8'h00);
        checks++; if (d0_data_oe !== 1'b0) begin fails++; $display("[TB] FAIL unsel_read_oe got %0h want 0", d0_data_oe); end
        checks++; if (d0_data_out !== 8'h00) begin fails++; $display("[TB] FAIL unsel_read_dout got %0h want 0", d0_data_out); end
        step(C_INACT, 8'h00);
    endtask

    task automatic test_tone();
        step(C_LATCH, 8'h00);
        step(C_WRITE, 8'hFF);
        step(C_LATCH, 8'h01);
        step(C_WRITE, 8'hFF);
        step(C_READ, 8'h00);
        checks++; if (d0_tone_a !== 12'hFFF) begin fails++; $display("[TB] FAIL tone_a got %0h want fff", d0_tone_a); end
        checks++; if (d0_data_oe !== 1'b1) begin fails++; $display("[TB] FAIL tone_read_oe got %0h want 1", d0_data_oe); end
        checks++; if (d0_data_out !== 8'h0F) begin fails++; $display("[TB] FAIL tone_read_r1 got %0h want 0f", d0_data_out); end
        checks++; if (d0_tone_b !== 12'h000) begin fails++; $display("[TB] FAIL tone_b got %0h want 0", d0_tone_b); end
        step(C_INACT, 8'h00);
        checks++; if (d0_data_oe !== 1'b0) begin fails++; $display("[TB] FAIL tone_oe_fall got %0h want 0", d0_data_oe); end
    endtask

    task automatic test_envelope();
        step(C_LATCH, 8'h0D);
        step(C_WRITE, 8'h0E);
        checks++; if (d0_env_restart !== 1'b0) begin fails++; $display("[TB] FAIL env_early got %0h want 0", d0_env_restart); end
        step(C_IDLE2, 8'h00);
        checks++; if (d0_env_restart !== 1'b1) begin fails++; $display("[TB] FAIL env_pulse1 got %0h want 1", d0_env_restart); end
        checks++; if ({d0_cont, d0_att, d0_alt, d0_hold} !== 4'hE) begin fails++; $display("[TB] FAIL env_shape got %0h want e", {d0_cont, d0_att, d0_alt, d0_hold}); end
        step(C_INACT, 8'h00);
        checks++; if (d0_env_restart !== 1'b0) begin fails++; $display("[TB] FAIL env_pulse1_end got %0h want 0", d0_env_restart); end
        step(C_WRITE, 8'h0E);
        step(C_INACT, 8'h00);
        checks++; if (d0_env_restart !== 1'b1) begin fails++; $display("[TB] FAIL env_pulse2 got %0h want 1", d0_env_restart); end
        step(C_INACT, 8'h00);
        checks++; if (d0_env_restart !== 1'b0) begin fails++; $display("[TB] FAIL env_pulse2_end got %0h want 0", d0_env_restart); end
        step(C_READ, 8'h00);
        checks++; if (d0_data_out !== 8'h0E) begin fails++; $display("[TB] FAIL env_read_r13 got %0h want 0e", d0_data_out); end
        step(C_INACT, 8'h00);
    endtask

    task automatic test_chip_select();
        step(C_LATCH, 8'h07);
        step(C_WRITE, 8'h3F);
        step(C_INACT, 8'h00);
        checks++; if (d1_mixer !== 8'h00) begin fails++; $display("[TB] FAIL cs_other_chip got %0h want 0", d1_mixer); end
        checks++; if (d0_mixer !== 8'h3F) begin fails++; $display("[TB] FAIL cs_chip0 got %0h want 3f", d0_mixer); end
        step(C_LATCH, 8'h17);
        step(C_WRITE, 8'h3F);
        step(C_INACT, 8'h00);
        checks++; if (d1_mixer !== 8'h3F) begin fails++; $display("[TB] FAIL cs_chip1 got %0h want 3f", d1_mixer); end
        step(C_READ, 8'h00);
        checks++; if (d0_data_oe !== 1'b0) begin fails++; $display("[TB] FAIL cs_unsel_oe got %0h want 0", d0_data_oe); end
        checks++; if ({d1_data_oe, d1_data_out} !== 9'h13F) begin fails++; $display("[TB] FAIL cs_sel_read got %0h want 13f", {d1_data_oe, d1_data_out}); end
        step(C_INACT, 8'h00);
    endtask

    task automatic test_reset_abort();
        step(C_LATCH, 8'h08);
        step(C_WRITE, 8'h1F);
        reset = 1'b1;
        step(C_WRITE, 8'h1F);
        reset = 1'b0;
        step(C_INACT, 8'h00);
        checks++; if (d0_amp_a !== 5'h00) begin fails++; $display("[TB] FAIL abort_amp_a got %0h want 0", d0_amp_a); end
        step(C_LATCH, 8'h0D);
        step(C_WRITE, 8'h03);
        reset = 1'b1;
        step(C_WRITE, 8'h03);
        checks++; if (d0_env_restart !== 1'b0) begin fails++; $display("[TB] FAIL abort_restart_rst got %0h want 0", d0_env_restart); end
        reset = 1'b0;
        step(C_INACT, 8'h00);
        checks++; if (d0_env_restart !== 1'b0) begin fails++; $display("[TB] FAIL abort_restart got %0h want 0", d0_env_restart); end
        checks++; if ({d0_alt, d0_hold} !== 2'b00) begin fails++; $display("[TB] FAIL abort_shape got %0h want 0", {d0_alt, d0_hold}); end
    endtask

    task automatic test_back_to_back();
        step(C_LATCH, 8'h0B);
        step(C_WRITE, 8'h34);
        step(C_LAT2, 8'h0C);
        checks++; if (d0_env_period !== 16'h0034) begin fails++; $display("[TB] FAIL b2b_r11 got %0h want 0034", d0_env_period); end
        step(C_WRITE, 8'h12);
        step(C_INACT, 8'h00);
        checks++; if (d0_env_period !== 16'h1234) begin fails++; $display("[TB] FAIL b2b_env_period got %0h want 1234", d0_env_period); end
        step(C_LAT3, 8'h0E);
        step(C_READ, 8'h00);
        checks++; if ({d0_data_oe, d0_data_out} !== 9'h100) begin fails++; $display("[TB] FAIL r14_read got %0h want 100", {d0_data_oe, d0_data_out}); end
        step(C_WRITE, 8'h55);
        checks++; if (d0_data_oe !== 1'b0) begin fails++; $display("[TB] FAIL r14_oe_fall got %0h want 0", d0_data_oe); end
        step(C_READ, 8'h00);
        checks++; if ({d0_data_oe, d0_data_out} !== 9'h100) begin fails++; $display("[TB] FAIL r14_discard got %0h want 100", {d0_data_oe, d0_data_out}); end
        step(C_INACT, 8'h00);
    endtask

    task automatic test_commit_read();
        step(C_LATCH, 8'h06);
        step(C_WRITE, 8'hFF);
        step(C_READ, 8'h00);
        checks++; if ({d0_data_oe, d0_data_out} !== 9'h11F) begin fails++; $display("[TB] FAIL commit_read got %0h want 11f", {d0_data_oe, d0_data_out}); end
        checks++; if (d0_noise !== 5'h1F) begin fails++; $display("[TB] FAIL noise got %0h want 1f", d0_noise); end
        step(C_INACT, 8'h00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1;
        {bdir, bc2, bc1} = C_INACT;
        data_in = 8'h00;
        @(negedge clk);
        test_reset();
        test_tone();
        test_envelope();
        test_chip_select();
        test_reset_abort();
        test_back_to_back();
        test_commit_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
